cpu_run_controller: RTL and testbench
=====================================

# cpu_run_controller

Clock-enable and run/step controller for the CPU core. Sits directly downstream of the board clock divider stage and directly upstream of the datapath, taking the single system clock plus front-panel run switch and step button and producing a one-cycle `cpu_en` strobe that gates every architectural register update. Supports free-run at a programmable rate, halted, and single-step modes, and honours a halt request from the CPU's control unit.

## Interface
- `DIV_W`, 3: width of the rate-select input `div`.
- `DEBOUNCE`, 16: cycles `step` must be stable high after synchronisation to count as pressed; minimum 1.
- `CNT_W`, 16: width of `cycle_count`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  asynchronous level switch; 1 = run, 0 = halt.
- `step`  in  1  asynchronous raw push-button; bounces.
- `halt_req`  in  1  synchronous one-cycle pulse from the control unit (HALT instruction).
- `div`  in  DIV_W  synchronous rate select; in RUN, one strobe every `div`+1 clocks.
- `cpu_en`  out  1  registered one-cycle enable strobe to the datapath.
- `halted`  out  1  registered; 1 while FSM is in HALT.
- `cycle_count`  out  CNT_W  registered count of `cpu_en` strobes issued.

## Operation
- Synchronisers: `run` and `step` each pass a 2-flop synchroniser (`run_s`, `step_s`). All decisions use synchronised values only.
- Debounce: counter increments while `step_s`=1, clears to 0 when `step_s`=0, saturates at `DEBOUNCE`. Debounced level `step_db`=1 when counter = `DEBOUNCE`. `step_ev` = rising edge of `step_db` (one cycle). One press = one `step_ev` regardless of hold length or bounce shorter than `DEBOUNCE`.
- Halt lock: `lock` set on `halt_req`; cleared in any cycle with `run_s`=0. Prevents auto-restart after a HALT instruction while the switch is still up.
- Rate counter `cnt` (DIV_W bits): 0 on reset and whenever state ≠ RUN. In RUN: if `cnt` >= `div`, `cnt`<=0 and a strobe is due; else `cnt`<=`cnt`+1. `>=` makes a mid-run decrease of `div` take effect without wrap-around.
- FSM states HALT, RUN, STEP:
  - HALT: `run_s`=1 and `lock`=0 -> RUN; else `step_ev` -> STEP; else stay. Run takes priority over step when both occur.
  - RUN: `halt_req`=1 -> HALT (any strobe due that cycle is suppressed); else `run_s`=0 -> HALT; else stay, issue strobe when due.
  - STEP: always -> HALT next edge; issues exactly one strobe. `halt_req` in STEP sets `lock`, strobe still issued. `step_ev` in RUN or STEP is ignored.
- `cpu_en` register: loaded 1 on the edge where the FSM is in STEP, or in RUN with a strobe due and no `halt_req`/`run_s`=0 that cycle; else 0. Never high two consecutive cycles except when `div`=0 in RUN.
- `cycle_count` increments by 1 on each edge where `cpu_en` is 1, wraps from all-ones to 0.
- `halted` <= (next state = HALT).

## Timing
- Reset (`rst_n`=0, asynchronous): state HALT, `cpu_en`=0, `halted`=1, `cycle_count`=0, `cnt`=0, `lock`=0, synchronisers and debounce counter 0. Release is synchronous to next `clk` edge.
- `run` rise to RUN: 2 edges synchroniser + 1 edge transition = 3 edges; first `cpu_en` high `div`+1 edges after entering RUN, then every `div`+1 cycles.
- `run` fall to last possible strobe: strobes stop within 3 edges; `cpu_en` 0 from the edge the FSM leaves RUN.
- `halt_req` at edge N (in RUN): state HALT and `cpu_en`=0 after edge N; `halted`=1 after edge N.
- Step: `step` stable high from edge 0 -> `step_db` after 2+`DEBOUNCE` edges -> STEP next edge -> `cpu_en` high for exactly one cycle next edge, state HALT same edge.
- Reset mid-operation: all state cleared immediately, no partial strobe emitted after `rst_n` asserts.

## Test plan
- Reset: hold `rst_n`=0 with `run`=1 -> `cpu_en`=0, `halted`=1, `cycle_count`=0; release -> first `cpu_en` 3+`div`+1 edges later.
- Free run, `div`=2, 30 cycles in RUN -> `cpu_en` every 3rd cycle, `cycle_count`=10; change `div` to 0 while `cnt`=2 -> strobe next edge, then every cycle.
- HALT instruction: RUN, `div`=0, pulse `halt_req` -> `cpu_en`=0 and `halted`=1 after that edge; keep `run`=1 100 cycles -> stays halted; drop and raise `run` -> resumes.
- Single step, `DEBOUNCE`=4: in HALT, bounce `step` 0/1 every 2 cycles for 20 cycles then hold high 50 cycles -> exactly one `cpu_en` pulse, `cycle_count` +1; press in RUN -> no extra pulse.
- Simultaneous `run` rise and `step_ev` in HALT -> enters RUN, no STEP pulse; `cycle_count` wraps 0xFFFF -> 0x0000 on next strobe (`CNT_W`=16).

Source files
------------

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_controller
//  Purpose  : Run / halt / single-step controller producing the one-cycle
//             cpu_en strobe that gates every architectural register update.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_controller #(
  parameter int DIV_W    = 3,
  parameter int DEBOUNCE = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [DIV_W-1:0] div,
  output logic             cpu_en,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  // Debounce counter only needs to reach DEBOUNCE, then it saturates.
  localparam int             DB_W   = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             run_m;
  logic             run_s;
  logic             step_m;
  logic             step_s;
  logic [DB_W-1:0]  db_cnt;
  logic             step_db;
  logic             step_db_q;
  logic             step_ev;
  logic             lock;
  logic [DIV_W-1:0] cnt;
  logic             due;
  logic             en_next;

  // Two-flop synchronisers for the asynchronous panel inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_m  <= 1'b0;
      run_s  <= 1'b0;
      step_m <= 1'b0;
      step_s <= 1'b0;
    end else begin
      run_m  <= run;
      run_s  <= run_m;
      step_m <= step;
      step_s <= step_m;
    end
  end

  // Saturating debounce counter; any low sample restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      step_db_q <= 1'b0;
    end else begin
      if (!step_s) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      step_db_q <= step_db;
    end
  end

  assign step_db = (db_cnt == DB_MAX);
  // One event per press: only the rising edge of the debounced level counts.
  assign step_ev = step_db & ~step_db_q;

  // Halt lock: a HALT instruction keeps the core stopped until the run
  // switch has been seen low, so a raised switch cannot auto-restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
    end else if (!run_s) begin
      lock <= 1'b0;
    end else if (halt_req) begin
      lock <= 1'b1;
    end
  end

  // Rate divider; '>=' lets a mid-run decrease of div apply without wrapping.
  assign due = (state == ST_RUN) && (cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != ST_RUN) begin
      cnt <= '0;
    end else if (cnt >= div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HALT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decision; run wins over a coincident step event.
  always_comb begin
    next_state = state;
    en_next    = 1'b0;
    case (state)
      ST_HALT: begin
        if (run_s && !lock) begin
          next_state = ST_RUN;
        end else if (step_ev) begin
          next_state = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req || !run_s) begin
          next_state = ST_HALT;
        end else begin
          en_next = due;
        end
      end
      ST_STEP: begin
        next_state = ST_HALT;
        en_next    = 1'b1;
      end
      default: begin
        next_state = ST_HALT;
      end
    endcase
  end

  // Registered outputs: strobe, halted flag and strobe counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en      <= 1'b0;
      halted      <= 1'b1;
      cycle_count <= '0;
    end else begin
      cpu_en <= en_next;
      halted <= (next_state == ST_HALT);
      if (cpu_en) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_controller
//  Purpose  : Self-checking bench for cpu_run_controller (DEBOUNCE = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_controller;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [2:0]  div;
  logic        cpu_en;
  logic        halted;
  logic [15:0] cycle_count;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        run;
    logic        step;
    logic        halt_req;
    logic [2:0]  div;
    logic        exp_en;
    logic        exp_halted;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [40];

  cpu_run_controller #(
    .DIV_W    (3),
    .DEBOUNCE (4),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .div         (div),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int          acc;
    int          ones;
    int          lat;
    logic        found;
    logic [15:0] base;

    n_checks = 0;
    n_fail   = 0;

    // Free-run table: released from reset with run held high, div = 2 for
    // edges 1..35 (strobes on edges 6, 9, ... 33), then div = 0 from edge 36
    // while cnt = 2, giving a strobe on every edge after that.
    acc = 0;
    for (int k = 1; k <= 40; k++) begin
      vecs[k-1].run        = 1'b1;
      vecs[k-1].step       = 1'b0;
      vecs[k-1].halt_req   = 1'b0;
      vecs[k-1].div        = (k <= 35) ? 3'd2 : 3'd0;
      vecs[k-1].exp_en     = ((k >= 6) && (k <= 35) && (((k - 6) % 3) == 0)) || (k >= 36);
      vecs[k-1].exp_halted = (k <= 2);
      vecs[k-1].exp_count  = acc[15:0];
      if (vecs[k-1].exp_en) acc++;
    end

    // Reset with the run switch already up.
    rst_n    = 1'b0;
    run      = 1'b1;
    step     = 1'b0;
    halt_req = 1'b0;
    div      = 3'd2;
    repeat (3) tick();
    chk("reset_en", cpu_en, 0);
    chk("reset_halted", halted, 1);
    chk("reset_count", cycle_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run      = vecs[i].run;
      step     = vecs[i].step;
      halt_req = vecs[i].halt_req;
      div      = vecs[i].div;
      tick();
      chk($sformatf("vec%0d_en", i + 1), cpu_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_halted", i + 1), halted, vecs[i].exp_halted);
      chk($sformatf("vec%0d_count", i + 1), cycle_count, vecs[i].exp_count);
    end

    // HALT instruction in RUN with div = 0: 14 strobes counted so far, the
    // strobe from edge 40 is counted on the halt edge.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_en", cpu_en, 0);
    chk("halt_halted", halted, 1);
    chk("halt_count", cycle_count, 15);
    ones = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (cpu_en) ones++;
    end
    chk("halt_locked_pulses", ones, 0);
    chk("halt_locked_halted", halted, 1);
    chk("halt_locked_count", cycle_count, 15);

    // Cycling the switch clears the lock; resume latency 3 + div + 1.
    run = 1'b0;
    repeat (5) tick();
    run = 1'b1;
    lat = 0;
    for (int t = 1; t <= 20 && lat == 0; t++) begin
      tick();
      if (cpu_en) lat = t;
    end
    chk("resume_latency", lat, 4);

    // Run switch falls while strobing every cycle.
    run = 1'b0;
    tick();
    chk("fall_e1_en", cpu_en, 1);
    tick();
    chk("fall_e2_en", cpu_en, 1);
    tick();
    chk("fall_e3_en", cpu_en, 0);
    chk("fall_e3_halted", halted, 1);
    repeat (3) tick();
    base = cycle_count;

    // Bouncing button never qualifies, then a long hold gives one step.
    ones = 0;
    for (int c = 0; c < 20; c++) begin
      step = ((c % 4) < 2);
      tick();
      if (cpu_en) ones++;
    end
    chk("bounce_pulses", ones, 0);
    step = 1'b1;
    ones = 0;
    lat  = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (cpu_en) begin
        ones++;
        if (lat == 0) lat = t;
      end
    end
    chk("step_pulses", ones, 1);
    chk("step_latency", lat, 8);
    step = 1'b0;
    repeat (5) tick();
    chk("step_count_delta", 32'(16'(cycle_count - base)), 1);
    chk("step_halted", halted, 1);

    // Step pressed during RUN (div = 7) adds nothing: 4 strobes in 32 edges.
    div = 3'd7;
    run = 1'b1;
    repeat (3) tick();
    chk("runpress_halted", halted, 0);
    step = 1'b1;
    ones = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      if (cpu_en) ones++;
    end
    chk("runpress_pulses", ones, 4);
    step = 1'b0;
    run  = 1'b0;
    repeat (8) tick();
    chk("runpress_back_halted", halted, 1);

    // run_s and step_ev coincide in HALT: run wins, no step strobe.
    div  = 3'd2;
    step = 1'b1;
    repeat (4) tick();
    run = 1'b1;
    repeat (3) tick();
    chk("simul_halted", halted, 0);
    tick();
    chk("simul_e8_en", cpu_en, 0);
    tick();
    chk("simul_e9_en", cpu_en, 0);
    tick();
    chk("simul_e10_en", cpu_en, 1);

    // Counter wrap at full rate.
    step  = 1'b0;
    div   = 3'd0;
    found = 1'b0;
    for (int t = 0; t < 70000 && !found; t++) begin
      tick();
      if (cycle_count == 16'hFFFF) found = 1'b1;
    end
    chk("wrap_reached", found, 1);
    chk("wrap_en_high", cpu_en, 1);
    tick();
    chk("wrap_count", cycle_count, 0);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", cpu_en, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_count", cycle_count, 0);
    repeat (2) tick();
    chk("midrst_hold_en", cpu_en, 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
